// File: rtl/mips_cpu_bus_arbiter.sv
// mips_cpu_bus_arbiter: round-robin arbiter sharing one Avalon-style memory port
// between the instruction-fetch master and the data master, one transfer at a time.
module mips_cpu_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_read,
  input  logic [ADDR_W-1:0]   i_address,
  output logic                i_waitrequest,
  output logic [DATA_W-1:0]   i_readdata,
  output logic                i_readdatavalid,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic [DATA_W/8-1:0] d_byteenable,
  input  logic [DATA_W-1:0]   d_writedata,
  output logic                d_waitrequest,
  output logic [DATA_W-1:0]   d_readdata,
  output logic                d_readdatavalid,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic                mem_waitrequest,
  input  logic [DATA_W-1:0]   mem_readdata
);
  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RDATA_I, RDATA_D} state_t;
  state_t r_state, w_state, w_next;
  logic r_last_d, w_next_last_d;
  logic w_i_req, w_d_req, w_acc;
  assign w_i_req = i_read;
  assign w_d_req = d_read ^ d_write;
  // Outputs decode as IDLE while reset is held, so an outstanding read is dropped at once
  assign w_state = reset ? IDLE : r_state;
  assign w_acc = (mem_read | mem_write) & ~mem_waitrequest;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_last_d <= 1'b1;
    end else begin
      r_state  <= w_next;
      r_last_d <= w_next_last_d;
    end
  end
  always_comb begin
    w_next         = IDLE;
    w_next_last_d  = r_last_d;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    case (w_state)
      IDLE: begin
        if (w_i_req && (!w_d_req || r_last_d)) begin
          w_next        = BUSY_I;
          w_next_last_d = 1'b0;
        end else if (w_d_req) begin
          w_next        = BUSY_D;
          w_next_last_d = 1'b1;
        end
      end
      BUSY_I: begin
        mem_read       = i_read;
        mem_address    = i_address;
        mem_byteenable = '1;
        w_next         = !i_read ? IDLE : mem_waitrequest ? BUSY_I : RDATA_I;
      end
      BUSY_D: begin
        mem_read       = w_d_req & d_read;
        mem_write      = w_d_req & d_write;
        mem_address    = d_address;
        mem_byteenable = d_byteenable;
        mem_writedata  = d_writedata;
        w_next         = !w_d_req ? IDLE : mem_waitrequest ? BUSY_D : d_read ? RDATA_D : IDLE;
      end
      default: ;
    endcase
  end
  assign i_waitrequest   = !(w_state == BUSY_I && w_acc);
  assign d_waitrequest   = !(w_state == BUSY_D && w_acc);
  assign i_readdatavalid = w_state == RDATA_I;
  assign d_readdatavalid = w_state == RDATA_D;
  assign i_readdata      = (w_state == RDATA_I) ? mem_readdata : '0;
  assign d_readdata      = (w_state == RDATA_D) ? mem_readdata : '0;
endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// tb_mips_cpu_bus_arbiter: directed checks of the two-master memory bus arbiter.
module tb_mips_cpu_bus_arbiter;
  logic        clk = 0, reset = 1;
  logic        i_read = 0, d_read = 0, d_write = 0, mem_waitrequest = 0;
  logic [31:0] i_address = 0, d_address = 0, d_writedata = 0, mem_readdata = 0;
  logic [3:0]  d_byteenable = 0;
  logic        i_waitrequest, i_readdatavalid, d_waitrequest, d_readdatavalid;
  logic        mem_read, mem_write;
  logic [31:0] i_readdata, d_readdata, mem_address, mem_writedata;
  logic [3:0]  mem_byteenable;
  int checks = 0, failures = 0;
  mips_cpu_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_waitrequest(i_waitrequest),
    .i_readdata(i_readdata), .i_readdatavalid(i_readdatavalid),
    .d_read(d_read), .d_write(d_write), .d_address(d_address),
    .d_byteenable(d_byteenable), .d_writedata(d_writedata),
    .d_waitrequest(d_waitrequest), .d_readdata(d_readdata), .d_readdatavalid(d_readdatavalid),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    logic [7:0] g;
    int n;
    logic both;
    // reset held two cycles with every request high
    i_read = 1; d_read = 1;
    tick(); tick();
    #1;
    chk("rst mem_read", mem_read, 0);
    chk("rst mem_write", mem_write, 0);
    chk("rst mem_address", mem_address, 0);
    chk("rst i_wait", i_waitrequest, 1);
    chk("rst d_wait", d_waitrequest, 1);
    chk("rst i_rdv", i_readdatavalid, 0);
    chk("rst d_rdv", d_readdatavalid, 0);
    reset = 0; i_read = 0; d_read = 0;
    tick(); #1;
    chk("idle mem_read", mem_read, 0);
    // single instruction read
    i_read = 1; i_address = 32'hBFC00000; mem_readdata = 32'h24020005;
    #1;
    chk("i c0 mem_read", mem_read, 0);
    tick(); #1;
    chk("i c1 mem_read", mem_read, 1);
    chk("i c1 be", mem_byteenable, 4'hF);
    chk("i c1 addr", mem_address, 32'hBFC00000);
    chk("i c1 i_wait", i_waitrequest, 0);
    chk("i c1 i_rdv", i_readdatavalid, 0);
    tick(); i_read = 0; #1;
    chk("i c2 i_rdv", i_readdatavalid, 1);
    chk("i c2 i_rdata", i_readdata, 32'h24020005);
    chk("i c2 mem_read", mem_read, 0);
    tick(); #1;
    chk("i c3 i_rdv", i_readdatavalid, 0);
    chk("i c3 i_rdata", i_readdata, 0);
    // I and D reads contend straight after reset
    reset = 1; tick(); reset = 0;
    i_read = 1; d_read = 1; i_address = 32'h100; d_address = 32'h200;
    g = 0; n = 0; both = 0;
    for (int c = 0; c < 24; c++) begin
      #1;
      if (i_readdatavalid && d_readdatavalid) both = 1;
      if (mem_read && !mem_waitrequest && n < 8) begin
        g[n] = !d_waitrequest;
        n++;
      end
      tick();
    end
    i_read = 0; d_read = 0;
    chk("rr grant count", n, 8);
    chk("rr grant order", g, 8'hAA);
    chk("rr both rdv", both, 0);
    // data write held off by three wait cycles
    tick(); #1;
    chk("w idle mem_write", mem_write, 0);
    d_write = 1; d_address = 32'h1000; d_byteenable = 4'b0011; d_writedata = 32'hDEADBEEF;
    mem_waitrequest = 1;
    for (int c = 1; c <= 3; c++) begin
      tick(); #1;
      chk("w stall mem_write", mem_write, 1);
      chk("w stall addr", mem_address, 32'h1000);
      chk("w stall be", mem_byteenable, 4'b0011);
      chk("w stall data", mem_writedata, 32'hDEADBEEF);
      chk("w stall d_wait", d_waitrequest, 1);
    end
    tick(); mem_waitrequest = 0; #1;
    chk("w acc d_wait", d_waitrequest, 0);
    chk("w acc mem_write", mem_write, 1);
    chk("w acc mem_read", mem_read, 0);
    tick(); d_write = 0; #1;
    chk("w after mem_write", mem_write, 0);
    chk("w after d_rdv", d_readdatavalid, 0);
    chk("w after d_wait", d_waitrequest, 1);
    // illegal d_read+d_write with a concurrent instruction read
    d_read = 1; d_write = 1; i_read = 1; i_address = 32'h400; mem_readdata = 32'h11111111;
    #1;
    chk("rw c0 d_wait", d_waitrequest, 1);
    tick(); #1;
    chk("rw c1 mem_read", mem_read, 1);
    chk("rw c1 mem_write", mem_write, 0);
    chk("rw c1 addr", mem_address, 32'h400);
    chk("rw c1 i_wait", i_waitrequest, 0);
    chk("rw c1 d_wait", d_waitrequest, 1);
    tick(); i_read = 0; #1;
    chk("rw c2 i_rdv", i_readdatavalid, 1);
    chk("rw c2 i_rdata", i_readdata, 32'h11111111);
    chk("rw c2 d_rdv", d_readdatavalid, 0);
    tick(); tick(); #1;
    chk("rw idle mem_read", mem_read, 0);
    chk("rw idle mem_write", mem_write, 0);
    chk("rw idle d_wait", d_waitrequest, 1);
    d_read = 0; d_write = 0;
    // reset lands in RDATA_D
    tick();
    d_read = 1; d_address = 32'h2000; mem_readdata = 32'hCAFEF00D;
    tick(); #1;
    chk("rd c1 mem_read", mem_read, 1);
    chk("rd c1 d_wait", d_waitrequest, 0);
    tick(); d_read = 0; reset = 1; #1;
    chk("rd rst d_rdv", d_readdatavalid, 0);
    chk("rd rst d_rdata", d_readdata, 0);
    tick(); reset = 0; i_read = 1; i_address = 32'h500; mem_readdata = 32'h22222222; #1;
    chk("rd post d_rdv", d_readdatavalid, 0);
    chk("rd post mem_read", mem_read, 0);
    tick(); #1;
    chk("rd i c1 mem_read", mem_read, 1);
    chk("rd i c1 i_wait", i_waitrequest, 0);
    tick(); i_read = 0; #1;
    chk("rd i c2 i_rdv", i_readdatavalid, 1);
    chk("rd i c2 i_rdata", i_readdata, 32'h22222222);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mips_cpu_bus_arbiter.md
Name: mips_cpu_bus_arbiter

Overview:
- Two-master to one-slave arbiter for the CPU's Avalon-style memory bus.
- Shares the single memory port between the instruction-fetch master (read-only) and the data master (read/write).
- Sits between the CPU core and the bus memory.
- Round-robin grant; one outstanding transfer at a time; fixed read latency of 1 cycle after acceptance.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports (byteenable is DATA_W/8)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
i_read  input  1  instruction master read request
i_address  input  ADDR_W  instruction address
i_waitrequest  output  1  instruction master stall
i_readdata  output  DATA_W  instruction read data
i_readdatavalid  output  1  i_readdata valid this cycle
d_read  input  1  data master read request
d_write  input  1  data master write request
d_address  input  ADDR_W  data address
d_byteenable  input  DATA_W/8  data byte lanes
d_writedata  input  DATA_W  data write value
d_waitrequest  output  1  data master stall
d_readdata  output  DATA_W  data read data
d_readdatavalid  output  1  d_readdata valid this cycle
mem_read  output  1  slave read strobe
mem_write  output  1  slave write strobe
mem_address  output  ADDR_W  slave address
mem_byteenable  output  DATA_W/8  slave byte lanes
mem_writedata  output  DATA_W  slave write data
mem_waitrequest  input  1  slave stall
mem_readdata  input  DATA_W  slave read data, valid the cycle after read acceptance

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- Request definitions:
  - I request = i_read.
  - D request = d_read XOR d_write.
  - d_read && d_write together is not a request: ignored, and d_waitrequest stays 1.
- Acceptance: a slave transfer is accepted in a cycle where (mem_read|mem_write) && !mem_waitrequest.
- State register states: IDLE, BUSY_I, BUSY_D, RDATA_I, RDATA_D. Registered flag last_d.
- IDLE: mem strobes 0.
  - Only one request present: go to that master's BUSY state.
  - Both present: last_d=1 -> BUSY_I; last_d=0 -> BUSY_D.
  - On entering BUSY_x, set last_d = (x==D).
- BUSY_x: mem_* driven combinationally from master x's live inputs.
  - Instruction grant: byteenable forced to all ones, writedata 0, mem_write 0.
  - Accepted read -> RDATA_x.
  - Accepted write -> IDLE.
  - Not accepted -> stay.
  - Master x drops its request before acceptance (protocol violation): mem strobes drop with it; -> IDLE next cycle.
- RDATA_x:
  - x_readdata = mem_readdata and x_readdatavalid = 1, for exactly this one cycle.
  - mem strobes 0; -> IDLE.
- x_waitrequest = 0 only in a BUSY_x cycle where the transfer is accepted; 1 otherwise.
- Non-granted readdata outputs: 0. readdatavalid is never asserted for writes.
- Minimum latency: request seen cycle 0 -> mem strobe cycle 1 -> data valid cycle 2.
- Throughput: read 3 cycles, write 2 cycles.
- Values after reset:
  - State IDLE, last_d=1 (instruction wins the first tie).
  - mem_read/mem_write 0, mem_address/byteenable/writedata 0.
  - i/d_waitrequest 1, readdatavalid 0, readdata 0.
- Reset mid-transfer (any state): next cycle IDLE. An outstanding read produces no readdatavalid, and its data is discarded.

Test Plan:
1. Reset held 2 cycles with all requests high -> all mem strobes 0, both waitrequests 1, both readdatavalid 0; IDLE after release.
2. i_read at 0xBFC00000, mem_waitrequest=0, mem returns 0x24020005 -> mem_read=1 with mem_byteenable=1111 in cycle 1; i_waitrequest=0 in cycle 1; i_readdatavalid=1 with i_readdata=0x24020005 in cycle 2 only.
3. I and D reads requested together for 4 transfers each, straight after reset -> grant order I,D,I,D...; no cycle has both readdatavalid high.
4. d_write addr 0x1000, byteenable 0011, data 0xDEADBEEF, mem_waitrequest high 3 cycles -> mem_* stable and d_waitrequest=1 for those 3 cycles; accepted on cycle 4; IDLE next; no d_readdatavalid.
5. d_read=d_write=1 -> no mem strobe, d_waitrequest stays 1; a concurrent i_read is still served normally.
6. Reset asserted in RDATA_D -> d_readdatavalid stays 0; a following i_read completes with latency 2.
